// File: rtl/decode_ctrl.sv
// Decode-stage controller: registers fetched instructions over a valid/ready
// handshake and decodes the main control bits and the extend select. A small
// FSM sequences load-use stalls and taken-branch flushes.
module decode_ctrl #(
    parameter int INSTR_W      = 30,
    parameter int STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] InstrF,
    input  logic               ValidF,
    output logic               ReadyD,
    input  logic               BranchTakenE,
    input  logic               MemtoRegE,
    input  logic               ValidE,
    input  logic [3:0]         RdE,
    output logic [INSTR_W-1:0] InstrD,
    output logic [1:0]         ImmSrcD,
    output logic               IssueD,
    output logic               RegWriteD,
    output logic               MemWriteD,
    output logic               MemtoRegD,
    output logic               BranchD,
    output logic               IllegalFlag
);

    typedef enum logic [1:0] {IDLE, RUN, STALL, FLUSH} state_t;

    typedef struct packed {
        logic reg_write;
        logic mem_write;
        logic mem_to_reg;
        logic branch;
    } ctrl_t;

    localparam logic [2:0] STALL_INIT = 3'(STALL_CYCLES - 1);
    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

    state_t     state;
    logic       valid_d;
    logic [2:0] cnt;
    ctrl_t      ctrl;
    logic [1:0] imm_src;

    // Instruction fields (positions assume a 30-bit instruction)
    logic [1:0] op;
    logic       imm_bit;
    logic       load_bit;
    logic [3:0] rn;
    logic [3:0] rm;

    assign op       = InstrD[29:28];
    assign imm_bit  = InstrD[27];
    assign load_bit = InstrD[26];
    assign rn       = InstrD[19:16];
    assign rm       = InstrD[3:0];

    logic illegal_op;
    logic hazard;
    logic transfer;

    assign illegal_op = (op == 2'b11);

    // Load-use: the execute-stage load writes a register this instruction reads.
    // Rm is only a source when the instruction is not in immediate form.
    assign hazard = valid_d && ValidE && MemtoRegE && !illegal_op &&
                    ((rn == RdE) || (!imm_bit && (rm == RdE)));

    // Fetch may transfer while idle/running without a hazard, and during a
    // flush so the wrong-path traffic drains; reset forces it low.
    assign ReadyD = reset &&
                    ((((state == IDLE) || (state == RUN)) && !hazard) ||
                     (state == FLUSH));

    assign transfer = ValidF && ReadyD;

    assign IssueD = reset && valid_d && (state == RUN) && !hazard &&
                    !BranchTakenE && !illegal_op;

    // Main decode of InstrD; reserved opcode leaves every control cleared
    always_comb begin
        ctrl    = '0;
        imm_src = 2'b00;
        case (op)
            2'b00: ctrl.reg_write = 1'b1;
            2'b01: begin
                imm_src = 2'b01;
                if (load_bit) begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.mem_to_reg = 1'b1;
                end else begin
                    ctrl.mem_write = 1'b1;
                end
            end
            2'b10: begin
                imm_src     = 2'b10;
                ctrl.branch = 1'b1;
            end
            default: ;
        endcase
    end

    // The extend select stays live for the extend unit; controls only when issuing
    assign ImmSrcD   = imm_src;
    assign RegWriteD = IssueD && ctrl.reg_write;
    assign MemWriteD = IssueD && ctrl.mem_write;
    assign MemtoRegD = IssueD && ctrl.mem_to_reg;
    assign BranchD   = IssueD && ctrl.branch;

    // Decode FSM: a taken branch overrides everything, then flush/stall counting,
    // then normal acceptance of fetch traffic
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            InstrD  <= '0;
            valid_d <= 1'b0;
            cnt     <= '0;
        end else if (BranchTakenE) begin
            valid_d <= 1'b0;
            cnt     <= FLUSH_INIT;
            state   <= FLUSH;
        end else begin
            case (state)
                FLUSH: begin
                    if (cnt == 3'd0) state <= IDLE;
                    else             cnt   <= cnt - 3'd1;
                end
                STALL: begin
                    if (cnt == 3'd0) state <= RUN;
                    else             cnt   <= cnt - 3'd1;
                end
                IDLE: begin
                    if (transfer) begin
                        InstrD  <= InstrF;
                        valid_d <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (hazard) begin
                        cnt   <= STALL_INIT;
                        state <= STALL;
                    end else if (transfer) begin
                        InstrD  <= InstrF;
                        valid_d <= 1'b1;
                    end else begin
                        valid_d <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky flag: a reserved opcode has occupied the RUN slot
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            IllegalFlag <= 1'b0;
        else if ((state == RUN) && valid_d && illegal_op)
            IllegalFlag <= 1'b1;
    end

endmodule

// File: tb/tb_decode_ctrl.sv
// Bench for decode_ctrl: expected issues are queued as instructions are driven
// and checked in order when IssueD fires; cycle-level checks cover handshake,
// stall, flush, illegal opcode and asynchronous reset.
module tb_decode_ctrl;

    logic        clk;
    logic        reset;
    logic [29:0] InstrF;
    logic        ValidF;
    logic        ReadyD;
    logic        BranchTakenE;
    logic        MemtoRegE;
    logic        ValidE;
    logic [3:0]  RdE;
    logic [29:0] InstrD;
    logic [1:0]  ImmSrcD;
    logic        IssueD;
    logic        RegWriteD;
    logic        MemWriteD;
    logic        MemtoRegD;
    logic        BranchD;
    logic        IllegalFlag;

    decode_ctrl #(.INSTR_W(30), .STALL_CYCLES(1), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .InstrF(InstrF), .ValidF(ValidF), .ReadyD(ReadyD),
        .BranchTakenE(BranchTakenE), .MemtoRegE(MemtoRegE), .ValidE(ValidE), .RdE(RdE),
        .InstrD(InstrD), .ImmSrcD(ImmSrcD), .IssueD(IssueD), .RegWriteD(RegWriteD),
        .MemWriteD(MemWriteD), .MemtoRegD(MemtoRegD), .BranchD(BranchD),
        .IllegalFlag(IllegalFlag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [29:0] instr;
        logic [5:0]  ctl;   // {RegWrite, MemWrite, MemtoReg, Branch, ImmSrc}
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;

    localparam logic [29:0] I_DP    = 30'h0000_1005;
    localparam logic [29:0] I_LOAD  = 30'h1400_1000;
    localparam logic [29:0] I_STORE = 30'h1000_2000;
    localparam logic [29:0] I_BR    = 30'h2000_0010;
    localparam logic [29:0] I_IMM   = 30'h0800_0004;  // I=1, Rm=4
    localparam logic [29:0] I_RN4   = 30'h0004_1002;  // Rn=4
    localparam logic [29:0] I_RM4   = 30'h0000_0004;  // I=0, Rm=4
    localparam logic [29:0] I_ILL   = 30'h3000_0000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] ref_ctl(input logic [29:0] i);
        case (i[29:28])
            2'b00:   return 6'b100000;
            2'b01:   return i[26] ? 6'b101001 : 6'b010001;
            2'b10:   return 6'b000110;
            default: return 6'b000000;
        endcase
    endfunction

    // Drive one cycle of inputs just after the edge, optionally queue the
    // expected issue, and return at mid-cycle for checks
    task automatic drive(input logic v, input logic [29:0] ins, input logic br,
                         input logic me, input logic ve, input logic [3:0] rd,
                         input logic push);
        @(posedge clk);
        #1;
        ValidF       = v;
        InstrF       = ins;
        BranchTakenE = br;
        MemtoRegE    = me;
        ValidE       = ve;
        RdE          = rd;
        if (push) sb.push_back({ins, ref_ctl(ins)});
        @(negedge clk);
    endtask

    // Scoreboard monitor: every issue must match the oldest queued instruction;
    // otherwise all gated controls must be low
    always @(negedge clk) begin
        if (reset) begin
            if (IssueD) begin
                if (sb.size() == 0) begin
                    chk("spurious_issue", 32'(sb.size()), 32'd1);
                end else begin
                    mon_e = sb.pop_front();
                    chk("issue_instr", 32'(InstrD), 32'(mon_e.instr));
                    chk("issue_ctl", 32'({RegWriteD, MemWriteD, MemtoRegD, BranchD, ImmSrcD}),
                        32'(mon_e.ctl));
                end
            end else begin
                chk("gated_ctl", 32'({RegWriteD, MemWriteD, MemtoRegD, BranchD}), 32'd0);
            end
        end
    end

    initial begin
        logic [29:0] hz [2];
        reset        = 1'b0;
        ValidF       = 1'b0;
        InstrF       = '0;
        BranchTakenE = 1'b0;
        MemtoRegE    = 1'b0;
        ValidE       = 1'b0;
        RdE          = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(ReadyD), 32'd0);
        chk("rst_issue", 32'(IssueD), 32'd0);
        chk("rst_instr", 32'(InstrD), 32'd0);
        chk("rst_illegal", 32'(IllegalFlag), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Back-to-back data-processing stream, one-cycle latency
        for (int i = 0; i < 4; i++) begin
            drive(i < 3, I_DP, 1'b0, 1'b0, 1'b0, 4'd0, i < 3);
            chk("t1_ready", 32'(ReadyD), 32'd1);
            chk("t1_issue", 32'(IssueD), (i > 0) ? 32'd1 : 32'd0);
        end

        // Load, store, branch, immediate form (Rm match must not hazard when I=1)
        drive(1'b1, I_LOAD,  1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        drive(1'b1, I_STORE, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        drive(1'b1, I_BR,    1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        drive(1'b1, I_IMM,   1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        drive(1'b0, '0,      1'b0, 1'b1, 1'b1, 4'd4, 1'b0);
        chk("t2_imm_nohaz", 32'(IssueD), 32'd1);

        // Load-use via Rn and via Rm: detect cycle, one stall cycle, then issue
        hz[0] = I_RN4;
        hz[1] = I_RM4;
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, hz[k], 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
            drive(1'b0, '0, 1'b0, 1'b1, 1'b1, 4'd4, 1'b0);
            chk("t3_haz_issue", 32'(IssueD), 32'd0);
            chk("t3_haz_ready", 32'(ReadyD), 32'd0);
            drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
            chk("t3_stall_issue", 32'(IssueD), 32'd0);
            chk("t3_stall_ready", 32'(ReadyD), 32'd0);
            drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
            chk("t3_resume", 32'(IssueD), 32'd1);
        end

        // Taken branch with fetch streaming: wrong-path work dropped, flush drains
        drive(1'b1, 30'h0000_A001, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        drive(1'b1, 30'h0000_A002, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        drive(1'b1, 30'h0000_A003, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        chk("t4_br_issue", 32'(IssueD), 32'd0);
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 30'h0000_A004 + 30'(k), 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
            chk("t4_flush_issue", 32'(IssueD), 32'd0);
            chk("t4_flush_ready", 32'(ReadyD), 32'd1);
        end
        drive(1'b1, 30'h0000_A006, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        chk("t4_idle_ready", 32'(ReadyD), 32'd1);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        chk("t4_third_issue", 32'(IssueD), 32'd1);

        // Branch and hazard together: flush wins, no stall cycle
        drive(1'b1, I_RN4, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b1, 1'b1, 4'd4, 1'b0);
        chk("t5_issue", 32'(IssueD), 32'd0);
        drive(1'b1, 30'h0000_B001, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        chk("t5_flush_ready0", 32'(ReadyD), 32'd1);
        drive(1'b1, 30'h0000_B002, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        chk("t5_flush_ready1", 32'(ReadyD), 32'd1);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);

        // Reserved opcode: no controls, sticky flag
        drive(1'b1, I_ILL, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        chk("t6_ill_issue", 32'(IssueD), 32'd0);
        chk("t6_ill_imm", 32'(ImmSrcD), 32'd0);
        chk("t6_ill_flag0", 32'(IllegalFlag), 32'd0);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        chk("t6_ill_flag1", 32'(IllegalFlag), 32'd1);
        drive(1'b1, I_DP, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        chk("t6_flag_sticky", 32'(IllegalFlag), 32'd1);

        // Asynchronous reset while stalled
        drive(1'b1, I_RN4, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b1, 1'b1, 4'd4, 1'b0);
        chk("t6_haz_ready", 32'(ReadyD), 32'd0);
        @(posedge clk);
        #1;
        MemtoRegE = 1'b0;
        ValidE    = 1'b0;
        RdE       = '0;
        #1;
        chk("t6_in_stall", 32'(ReadyD), 32'd0);
        reset = 1'b0;
        #1;
        chk("t6_rst_ready", 32'(ReadyD), 32'd0);
        chk("t6_rst_issue", 32'(IssueD), 32'd0);
        chk("t6_rst_instr", 32'(InstrD), 32'd0);
        chk("t6_rst_flag", 32'(IllegalFlag), 32'd0);
        chk("t6_rst_ctl", 32'({RegWriteD, MemWriteD, MemtoRegD, BranchD, ImmSrcD}), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Recovery after reset
        drive(1'b1, I_LOAD, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        chk("t7_issue", 32'(IssueD), 32'd1);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
